// File: rtl/bitmap_wr_arbiter.sv
// Write-port owner for the dual-port bitmap RAM: round-robin between the dot and painter requesters,
// plus an optional full-map clear engine built only when BITMAP_CLEAR_EN is defined.
module bitmap_wr_arbiter #(
    parameter int MAP_SIZE_X = 7,
    parameter int MAP_SIZE_Y = 7,
    parameter int DATA_WIDTH = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req0_valid,
    input  logic [MAP_SIZE_X-1:0]        req0_x,
    input  logic [MAP_SIZE_Y-1:0]        req0_y,
    input  logic [DATA_WIDTH-1:0]        req0_data,
    output logic                         req0_ready,
    input  logic                         req1_valid,
    input  logic [MAP_SIZE_X-1:0]        req1_x,
    input  logic [MAP_SIZE_Y-1:0]        req1_y,
    input  logic [DATA_WIDTH-1:0]        req1_data,
    output logic                         req1_ready,
    input  logic                         clr_start,
    input  logic [DATA_WIDTH-1:0]        clr_color,
    output logic                         clr_busy,
    output logic                         clr_done,
    output logic                         ram_we,
    output logic [MAP_SIZE_X+MAP_SIZE_Y-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]        ram_din
);
    localparam int AW = MAP_SIZE_X + MAP_SIZE_Y;
    localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

    logic                  r_last_grant;
    logic                  r_we;
    logic [AW-1:0]         r_addr;
    logic [DATA_WIDTH-1:0] r_din;
    logic                  w_idle;
    logic                  w_clr_we;
    logic [AW-1:0]         w_clr_addr;
    logic [DATA_WIDTH-1:0] w_clr_data;
    logic                  w_grant0;
    logic                  w_grant1;

`ifdef BITMAP_CLEAR_EN
    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [AW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_color;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_start;

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (clr_start && !r_busy) begin
                    w_start      = 1'b1;
                    w_state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (r_cnt == LAST_ADDR)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // busy/done are registered with the sweep write so they line up with ram_addr
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_color <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_busy <= (r_state == S_CLEAR);
            r_done <= (r_state == S_CLEAR) && (r_cnt == LAST_ADDR);
            if (w_start) begin
                r_cnt   <= '0;
                r_color <= clr_color;
            end else if (r_state == S_CLEAR && r_cnt != LAST_ADDR) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign w_idle     = (r_state == S_IDLE) && !w_start;
    assign w_clr_we   = (r_state == S_CLEAR);
    assign w_clr_addr = r_cnt;
    assign w_clr_data = r_color;
    assign clr_busy   = r_busy;
    assign clr_done   = r_done;
`else
    logic w_unused;

    assign w_unused   = clr_start ^ (^clr_color);
    assign w_idle     = 1'b1;
    assign w_clr_we   = 1'b0;
    assign w_clr_addr = '0;
    assign w_clr_data = '0;
    assign clr_busy   = 1'b0;
    assign clr_done   = 1'b0;
`endif

    // on a tie the requester that did not win last time gets the port
    assign w_grant0 = w_idle && req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1 = w_idle && req1_valid && (!req0_valid || !r_last_grant);

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_din        <= '0;
            r_last_grant <= 1'b1;
        end else if (w_clr_we) begin
            r_we   <= 1'b1;
            r_addr <= w_clr_addr;
            r_din  <= w_clr_data;
        end else if (w_grant0) begin
            r_we         <= 1'b1;
            r_addr       <= {req0_y, req0_x};
            r_din        <= req0_data;
            r_last_grant <= 1'b0;
        end else if (w_grant1) begin
            r_we         <= 1'b1;
            r_addr       <= {req1_y, req1_x};
            r_din        <= req1_data;
            r_last_grant <= 1'b1;
        end else begin
            r_we <= 1'b0;
        end
    end

    assign ram_we   = r_we;
    assign ram_addr = r_addr;
    assign ram_din  = r_din;

endmodule

// File: tb/tb_bitmap_wr_arbiter.sv
// Bench for bitmap_wr_arbiter: directed stimulus, a behavioural model checked every cycle,
// and literal expectations; follows BITMAP_CLEAR_EN the same way as the design.
module tb_bitmap_wr_arbiter;
    localparam int MX = 7;
    localparam int MY = 7;
    localparam int DW = 3;
    localparam int AW = MX + MY;
    localparam int N  = 1 << AW;
`ifdef BITMAP_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0;
    logic [MX-1:0] req0_x = '0;
    logic [MY-1:0] req0_y = '0;
    logic [DW-1:0] req0_data = '0;
    logic          req0_ready;
    logic          req1_valid = 1'b0;
    logic [MX-1:0] req1_x = '0;
    logic [MY-1:0] req1_y = '0;
    logic [DW-1:0] req1_data = '0;
    logic          req1_ready;
    logic          clr_start = 1'b0;
    logic [DW-1:0] clr_color = '0;
    logic          clr_busy;
    logic          clr_done;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;

    int tests = 0;
    int fails = 0;

    bitmap_wr_arbiter #(.MAP_SIZE_X(MX), .MAP_SIZE_Y(MY), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y), .req0_data(req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y), .req1_data(req1_data),
        .req1_ready(req1_ready),
        .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy), .clr_done(clr_done),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: what the RAM port must show, derived from the arbitration rules
    bit m_clearing = 1'b0;
    int m_idx      = 0;
    int m_color    = 0;
    bit m_prefer1  = 1'b0;
    bit m_we       = 1'b0;
    int m_addr     = 0;
    int m_din      = 0;
    bit m_busy     = 1'b0;
    bit m_done     = 1'b0;

    bit e_start, e_accept, e_r0, e_r1;
    assign e_start  = CLR_EN && !m_clearing && clr_start && !m_busy;
    assign e_accept = !m_clearing && !e_start;
    assign e_r0 = e_accept && req0_valid && (!req1_valid || !m_prefer1);
    assign e_r1 = e_accept && req1_valid && (!req0_valid || m_prefer1);

    always @(posedge clk) begin
        if (rst) begin
            m_clearing <= 1'b0;
            m_idx      <= 0;
            m_prefer1  <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= 0;
            m_din      <= 0;
            m_busy     <= 1'b0;
            m_done     <= 1'b0;
        end else begin
            m_busy <= m_clearing;
            m_done <= m_clearing && (m_idx == N - 1);
            if (m_clearing) begin
                m_we   <= 1'b1;
                m_addr <= m_idx;
                m_din  <= m_color;
                if (m_idx == N - 1) m_clearing <= 1'b0;
                else                m_idx      <= m_idx + 1;
            end else if (e_start) begin
                m_clearing <= 1'b1;
                m_idx      <= 0;
                m_color    <= int'(clr_color);
                m_we       <= 1'b0;
            end else if (e_r0) begin
                m_we      <= 1'b1;
                m_addr    <= int'(req0_y) * (1 << MX) + int'(req0_x);
                m_din     <= int'(req0_data);
                m_prefer1 <= 1'b1;
            end else if (e_r1) begin
                m_we      <= 1'b1;
                m_addr    <= int'(req1_y) * (1 << MX) + int'(req1_x);
                m_din     <= int'(req1_data);
                m_prefer1 <= 1'b0;
            end else begin
                m_we <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check("m_req0_ready", 32'(req0_ready), 32'(e_r0));
        check("m_req1_ready", 32'(req1_ready), 32'(e_r1));
        check("m_ram_we", 32'(ram_we), 32'(m_we));
        if (m_we) begin
            check("m_ram_addr", 32'(ram_addr), m_addr);
            check("m_ram_din", 32'(ram_din), m_din);
        end
        check("m_clr_busy", 32'(clr_busy), 32'(m_busy));
        check("m_clr_done", 32'(clr_done), 32'(m_done));
    end

    int exp_r0 [4]   = '{1, 0, 1, 0};
    int exp_addr [4] = '{257, 515, 257, 515};
    int exp_din [4]  = '{1, 2, 1, 2};

    initial begin
        // reset held three cycles, then idle
        repeat (3) step();
        rst = 1'b0;
        step();
        step();
        check("rst_we", 32'(ram_we), 0);
        check("rst_addr", 32'(ram_addr), 0);
        check("rst_din", 32'(ram_din), 0);
        check("rst_busy", 32'(clr_busy), 0);
        check("rst_done", 32'(clr_done), 0);
        check("rst_ready0", 32'(req0_ready), 0);

        // single req0 write
        req0_valid = 1'b1; req0_x = 7'd50; req0_y = 7'd100; req0_data = 3'd5;
        #1;
        check("single_ready0", 32'(req0_ready), 1);
        step();
        req0_valid = 1'b0;
        check("single_we", 32'(ram_we), 1);
        check("single_addr", 32'(ram_addr), 12850);
        check("single_din", 32'(ram_din), 5);
        step();
        check("single_we_after", 32'(ram_we), 0);

        // both requesters from reset alternate 0,1,0,1
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0_valid = 1'b1; req0_x = 7'd1; req0_y = 7'd2; req0_data = 3'd1;
        req1_valid = 1'b1; req1_x = 7'd3; req1_y = 7'd4; req1_data = 3'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("alt_ready0", 32'(req0_ready), exp_r0[i]);
            check("alt_ready1", 32'(req1_ready), 1 - exp_r0[i]);
            step();
            check("alt_we", 32'(ram_we), 1);
            check("alt_addr", 32'(ram_addr), exp_addr[i]);
            check("alt_din", 32'(ram_din), exp_din[i]);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();

`ifdef BITMAP_CLEAR_EN
        begin
            int  writes;
            int  bad;
            int  rdy_bad;
            int  cyc;
            bit  done_seen;
            writes = 0; bad = 0; rdy_bad = 0; cyc = 0; done_seen = 1'b0;
            req1_valid = 1'b1; req1_x = 7'd9; req1_y = 7'd9; req1_data = 3'd6;
            clr_start = 1'b1; clr_color = 3'd3;
            #1;
            check("clr_start_blocks_req1", 32'(req1_ready), 0);
            step();
            clr_start = 1'b0; clr_color = 3'd0;
            while (!done_seen && cyc < 20000) begin
                step();
                cyc++;
                if (ram_we) begin
                    if (ram_addr !== AW'(writes) || ram_din !== 3'd3) bad++;
                    writes++;
                end
                if (req1_ready && !clr_done) rdy_bad++;
                if (clr_done) done_seen = 1'b1;
            end
            check("sweep_done_seen", 32'(done_seen), 1);
            check("sweep_writes", writes, N);
            check("sweep_seq_errors", bad, 0);
            check("sweep_req1_ready_errors", rdy_bad, 0);
            check("sweep_last_addr", 32'(ram_addr), 16383);
            check("sweep_busy_at_done", 32'(clr_busy), 1);
            check("sweep_req1_after", 32'(req1_ready), 1);
            step();
            req1_valid = 1'b0;
            check("post_clr_we", 32'(ram_we), 1);
            check("post_clr_addr", 32'(ram_addr), 1161);
            check("post_clr_din", 32'(ram_din), 6);
            check("post_clr_busy", 32'(clr_busy), 0);
            check("post_clr_done", 32'(clr_done), 0);
            step();

            // reset in the middle of a sweep
            clr_start = 1'b1; clr_color = 3'd2;
            step();
            clr_start = 1'b0;
            repeat (100) step();
            check("abort_pre_addr", 32'(ram_addr), 99);
            check("abort_pre_busy", 32'(clr_busy), 1);
            rst = 1'b1;
            step();
            check("abort_we", 32'(ram_we), 0);
            check("abort_busy", 32'(clr_busy), 0);
            check("abort_done", 32'(clr_done), 0);
            rst = 1'b0;
            step();
            check("abort_idle_we", 32'(ram_we), 0);
            clr_start = 1'b1;
            step();
            clr_start = 1'b0;
            step();
            check("restart_we", 32'(ram_we), 1);
            check("restart_addr", 32'(ram_addr), 0);
            check("restart_din", 32'(ram_din), 2);
            check("restart_busy", 32'(clr_busy), 1);
            rst = 1'b1;
            step();
            rst = 1'b0;
            step();
        end
`else
        req0_valid = 1'b1; req0_x = 7'd7; req0_y = 7'd1; req0_data = 3'd4;
        clr_start = 1'b1; clr_color = 3'd3;
        #1;
        check("noclr_ready0", 32'(req0_ready), 1);
        step();
        req0_valid = 1'b0;
        check("noclr_we", 32'(ram_we), 1);
        check("noclr_addr", 32'(ram_addr), 135);
        check("noclr_din", 32'(ram_din), 4);
        for (int i = 0; i < 4; i++) begin
            step();
            check("noclr_busy", 32'(clr_busy), 0);
            check("noclr_done", 32'(clr_done), 0);
            check("noclr_we_idle", 32'(ram_we), 0);
        end
        clr_start = 1'b0;
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
